// File: rtl/mem_responder.sv
// Word-addressed unified memory acting as the responder on the multicycle datapath port.
// One request at a time, LATENCY wait cycles, then a one-cycle MemReady pulse with error flag.
module mem_responder #(
   parameter int WORDS   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        MemErr,
   output logic        MemBusy
);

   localparam int          AW        = $clog2(WORDS);
   localparam logic [3:0]  LAT       = 4'(LATENCY);
   localparam logic [31:0] ADR_LIMIT = 32'(4 * WORDS);
   localparam logic [31:0] ERR_WORD  = 32'hDEADBEEF;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [3:0]    cnt;
   logic [3:0]    next_cnt;

   logic          lat_write;
   logic          lat_err;
   logic [AW-1:0] lat_idx;
   logic [31:0]   lat_wdata;

   logic          adr_err;
   logic          src_write;
   logic          src_err;
   logic [AW-1:0] src_idx;
   logic [31:0]   src_wdata;
   logic [31:0]   rsp_data;

   logic [31:0]   mem [WORDS];

   assign adr_err = (Adr[1:0] != 2'b00) || (Adr >= ADR_LIMIT);

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         S_IDLE: begin
            if (MemReq) begin
               next_cnt   = LAT;
               next_state = (LATENCY == 0) ? S_RESP : S_WAIT;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_WAIT: begin
            next_cnt = cnt - 4'd1;
            if (cnt <= 4'd1) begin
               next_state = S_RESP;
            end else begin
               next_state = S_WAIT;
            end
         end
         S_RESP:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // With LATENCY=0 the response is formed straight from the accept-cycle inputs.
   always_comb begin
      if (state == S_IDLE) begin
         src_write = MemWrite;
         src_err   = adr_err;
         src_idx   = Adr[AW+1:2];
         src_wdata = WriteData;
      end else begin
         src_write = lat_write;
         src_err   = lat_err;
         src_idx   = lat_idx;
         src_wdata = lat_wdata;
      end
      if (src_err) begin
         rsp_data = ERR_WORD;
      end else if (src_write) begin
         rsp_data = src_wdata;
      end else begin
         rsp_data = mem[src_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         ReadData <= 32'd0;
         MemReady <= 1'b0;
         MemErr   <= 1'b0;
         MemBusy  <= 1'b0;
      end else begin
         state    <= next_state;
         cnt      <= next_cnt;
         MemReady <= (next_state == S_RESP);
         MemErr   <= (next_state == S_RESP) && src_err;
         MemBusy  <= (next_state != S_IDLE);
         if (next_state == S_RESP) begin
            ReadData <= rsp_data;
         end else begin
            ReadData <= ReadData;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lat_write <= 1'b0;
         lat_err   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= 32'd0;
      end else if (state == S_IDLE && MemReq) begin
         lat_write <= MemWrite;
         lat_err   <= adr_err;
         lat_idx   <= Adr[AW+1:2];
         lat_wdata <= WriteData;
      end else begin
         lat_write <= lat_write;
         lat_err   <= lat_err;
         lat_idx   <= lat_idx;
         lat_wdata <= lat_wdata;
      end
   end

   // Commit happens on the edge leaving RESP so a reset during RESP still cancels the write.
   always_ff @(posedge clk) begin
      if (!reset && state == S_RESP && lat_write && !lat_err) begin
         mem[lat_idx] <= lat_wdata;
      end
   end

endmodule
